// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - strobe bus between the control sequencer and the single-bus datapath
interface control_sequencer_if;
  logic [31:0] IR_q;
  logic        mem_ready;
  logic [15:0] R_in;
  logic [15:0] R_out;
  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout, IRin, Yin;
  logic        Zin, Zlowout, Zhighout;
  logic        HIin, HIout, LOin, LOout;
  logic        Cout;
  logic        Read, Write;
  logic [12:0] alu_op;
  logic        run;
  logic        illegal;

  modport master (
    input  IR_q, mem_ready,
    output R_in, R_out, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
           Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout,
           Read, Write, alu_op, run, illegal
  );

  modport slave (
    output IR_q, mem_ready,
    input  R_in, R_out, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
           Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Cout,
           Read, Write, alu_op, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit sequencing fetch and per-opcode execute steps
module control_sequencer #(
  parameter int MEM_WAIT_LIMIT = 16
) (
  input  logic               clk,
  input  logic               reset,
  control_sequencer_if.master bus
);

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

  localparam logic [12:0] ALU_ADD  = 13'h1000, ALU_SUB = 13'h0800, ALU_MUL  = 13'h0400;
  localparam logic [12:0] ALU_DIV  = 13'h0200, ALU_AND = 13'h0100, ALU_OR   = 13'h0080;
  localparam logic [12:0] ALU_SHR  = 13'h0040, ALU_SHRA = 13'h0020, ALU_SHL = 13'h0010;
  localparam logic [12:0] ALU_ROR  = 13'h0008, ALU_ROL = 13'h0004, ALU_NEG  = 13'h0002;
  localparam logic [12:0] ALU_NOT  = 13'h0001;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_LIMIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;

  logic [4:0]  opcode;
  logic [15:0] ra_sel, rb_sel, rc_sel;
  logic [12:0] op_sel;
  logic        is_rtype, is_imm, is_ldi, is_ld, is_st, is_muldiv, is_unary;
  logic        is_mfhi, is_mflo, is_nop, is_halt;
  logic        mem_req;
  logic        unused_ir;

  assign opcode    = bus.IR_q[31:27];
  assign ra_sel    = 16'b1 << bus.IR_q[26:23];
  assign rb_sel    = 16'b1 << bus.IR_q[22:19];
  assign rc_sel    = 16'b1 << bus.IR_q[18:15];
  assign unused_ir = ^bus.IR_q[14:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    op_sel    = '0;
    is_rtype  = 1'b0;
    is_imm    = 1'b0;
    is_ldi    = 1'b0;
    is_ld     = 1'b0;
    is_st     = 1'b0;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    is_mfhi   = 1'b0;
    is_mflo   = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ADD:  begin is_rtype = 1'b1; op_sel = ALU_ADD;  end
      OP_SUB:  begin is_rtype = 1'b1; op_sel = ALU_SUB;  end
      OP_AND:  begin is_rtype = 1'b1; op_sel = ALU_AND;  end
      OP_OR:   begin is_rtype = 1'b1; op_sel = ALU_OR;   end
      OP_ROR:  begin is_rtype = 1'b1; op_sel = ALU_ROR;  end
      OP_ROL:  begin is_rtype = 1'b1; op_sel = ALU_ROL;  end
      OP_SHR:  begin is_rtype = 1'b1; op_sel = ALU_SHR;  end
      OP_SHRA: begin is_rtype = 1'b1; op_sel = ALU_SHRA; end
      OP_SHL:  begin is_rtype = 1'b1; op_sel = ALU_SHL;  end
      OP_ADDI: begin is_imm = 1'b1;   op_sel = ALU_ADD;  end
      OP_ANDI: begin is_imm = 1'b1;   op_sel = ALU_AND;  end
      OP_ORI:  begin is_imm = 1'b1;   op_sel = ALU_OR;   end
      OP_LDI:  begin is_ldi = 1'b1;   op_sel = ALU_ADD;  end
      OP_LD:   begin is_ld = 1'b1;    op_sel = ALU_ADD;  end
      OP_ST:   begin is_st = 1'b1;    op_sel = ALU_ADD;  end
      OP_MUL:  begin is_muldiv = 1'b1; op_sel = ALU_MUL; end
      OP_DIV:  begin is_muldiv = 1'b1; op_sel = ALU_DIV; end
      OP_NEG:  begin is_unary = 1'b1; op_sel = ALU_NEG;  end
      OP_NOT:  begin is_unary = 1'b1; op_sel = ALU_NOT;  end
      OP_MFHI: is_mfhi = 1'b1;
      OP_MFLO: is_mflo = 1'b1;
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Read/Write states; the hold below keys off state only so strobes never follow mem_ready
  assign mem_req = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    bus.R_in      = '0;
    bus.R_out     = '0;
    bus.PCout     = 1'b0;
    bus.PCin      = 1'b0;
    bus.IncPC     = 1'b0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zin       = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.HIin      = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOin      = 1'b0;
    bus.LOout     = 1'b0;
    bus.Cout      = 1'b0;
    bus.Read      = 1'b0;
    bus.Write     = 1'b0;
    bus.alu_op    = '0;
    bus.illegal   = 1'b0;
    bus.run       = (state != S_IDLE) && (state != S_HALT);

    case (state)
      S_IDLE: state_nxt = S_T0;
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        state_nxt = is_nop ? S_T0 : (is_halt ? S_HALT : S_T3);
      end
      S_T3: begin
        state_nxt = S_T4;
        if (is_rtype || is_imm || is_ldi || is_ld || is_st) begin
          bus.R_out = rb_sel; bus.Yin = 1'b1;
        end else if (is_muldiv) begin
          bus.R_out = ra_sel; bus.Yin = 1'b1;
        end else if (is_unary) begin
          bus.R_out = rb_sel; bus.alu_op = op_sel; bus.Zin = 1'b1;
        end else if (is_mfhi) begin
          bus.HIout = 1'b1; bus.R_in = ra_sel; state_nxt = S_T0;
        end else if (is_mflo) begin
          bus.LOout = 1'b1; bus.R_in = ra_sel; state_nxt = S_T0;
        end else begin
          bus.illegal = 1'b1; state_nxt = S_T0;
        end
      end
      S_T4: begin
        state_nxt = S_T5;
        if (is_rtype) begin
          bus.R_out = rc_sel; bus.alu_op = op_sel; bus.Zin = 1'b1;
        end else if (is_imm || is_ldi || is_ld || is_st) begin
          bus.Cout = 1'b1; bus.alu_op = op_sel; bus.Zin = 1'b1;
        end else if (is_muldiv) begin
          bus.R_out = rb_sel; bus.alu_op = op_sel; bus.Zin = 1'b1;
        end else begin
          bus.Zlowout = 1'b1; bus.R_in = ra_sel; state_nxt = S_T0;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        state_nxt   = S_T6;
        if (is_muldiv) begin
          bus.LOin = 1'b1;
        end else if (is_ld || is_st) begin
          bus.MARin = 1'b1;
        end else begin
          bus.R_in = ra_sel; state_nxt = S_T0;
        end
      end
      S_T6: begin
        state_nxt = S_T7;
        if (is_muldiv) begin
          bus.Zhighout = 1'b1; bus.HIin = 1'b1; state_nxt = S_T0;
        end else if (is_ld) begin
          bus.Read = 1'b1; bus.MDRin = 1'b1;
        end else begin
          bus.R_out = ra_sel; bus.MDRin = 1'b1;
        end
      end
      S_T7: begin
        state_nxt = S_T0;
        if (is_ld) begin
          bus.MDRout = 1'b1; bus.R_in = ra_sel;
        end else begin
          bus.Write = 1'b1;
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase

    if (mem_req) begin
      if (bus.mem_ready) begin
        wait_cnt_nxt = '0;
      end else if (wait_cnt == WAIT_LAST) begin
        state_nxt    = S_HALT;
        wait_cnt_nxt = '0;
      end else begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset;

  control_sequencer_if bus();

  control_sequencer #(.MEM_WAIT_LIMIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] RUN  = 20'h80000, ILL  = 20'h40000, RD   = 20'h20000, WR  = 20'h10000;
  localparam logic [19:0] PCO  = 20'h08000, PCI  = 20'h04000, INC  = 20'h02000, MARI = 20'h01000;
  localparam logic [19:0] MDRI = 20'h00800, MDRO = 20'h00400, IRI  = 20'h00200, YI  = 20'h00100;
  localparam logic [19:0] ZI   = 20'h00080, ZLO  = 20'h00040, ZHO  = 20'h00020, HII = 20'h00010;
  localparam logic [19:0] HIO  = 20'h00008, LOI  = 20'h00004, LOO  = 20'h00002, CO  = 20'h00001;
  localparam logic [19:0] NONE = 20'h00000;

  localparam logic [12:0] A_ADD = 13'h1000, A_MUL = 13'h0400, A_AND = 13'h0100, A_NEG = 13'h0002;
  localparam logic [12:0] A_NONE = 13'h0000;

  typedef struct {
    string       name;
    logic [64:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] act;

  assign act = {bus.run, bus.illegal, bus.Read, bus.Write, bus.PCout, bus.PCin, bus.IncPC,
                bus.MARin, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout,
                bus.Zhighout, bus.HIin, bus.HIout, bus.LOin, bus.LOout, bus.Cout,
                bus.alu_op, bus.R_in, bus.R_out};

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (act !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s: actual=%h required=%h", mon_e.name, act, mon_e.v);
      end
    end
  end

  task automatic cyc(input string name, input logic [19:0] s, input logic [12:0] a,
                     input logic [15:0] rin, input logic [15:0] rout, input logic rdy);
    exp_t e;
    bus.mem_ready = rdy;
    e.name = name;
    e.v    = {s, a, rin, rout};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ir);
    bus.IR_q = ir;
    cyc("T0", RUN|PCO|MARI|INC|ZI, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("T1", RUN|ZLO|PCI|RD|MDRI, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("T2", RUN|MDRO|IRI,        A_NONE, 16'h0, 16'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    bus.IR_q      = 32'h0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_hold", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("reset_hold", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    reset = 1'b1;
    cyc("idle", NONE, A_NONE, 16'h0, 16'h0, 1'b1);

    // add R3,R1,R2
    fetch(32'h19890000);
    cyc("add_T3", RUN|YI, A_NONE, 16'h0, 16'h0002, 1'b1);
    cyc("add_T4", RUN|ZI, A_ADD,  16'h0, 16'h0004, 1'b1);
    cyc("add_T5", RUN|ZLO, A_NONE, 16'h0008, 16'h0, 1'b1);

    // ld R2,0x65(R1) with three not-ready cycles at T6
    fetch(32'h01080065);
    cyc("ld_T3", RUN|YI,    A_NONE, 16'h0, 16'h0002, 1'b1);
    cyc("ld_T4", RUN|CO|ZI, A_ADD,  16'h0, 16'h0, 1'b1);
    cyc("ld_T5", RUN|ZLO|MARI, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("ld_T6_wait", RUN|RD|MDRI, A_NONE, 16'h0, 16'h0, 1'b0);
    cyc("ld_T6_wait", RUN|RD|MDRI, A_NONE, 16'h0, 16'h0, 1'b0);
    cyc("ld_T6_wait", RUN|RD|MDRI, A_NONE, 16'h0, 16'h0, 1'b0);
    cyc("ld_T6_rdy",  RUN|RD|MDRI, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("ld_T7", RUN|MDRO, A_NONE, 16'h0004, 16'h0, 1'b1);

    // mul R3,R1
    fetch(32'h81880000);
    cyc("mul_T3", RUN|YI, A_NONE, 16'h0, 16'h0008, 1'b1);
    cyc("mul_T4", RUN|ZI, A_MUL,  16'h0, 16'h0002, 1'b1);
    cyc("mul_T5", RUN|ZLO|LOI, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("mul_T6", RUN|ZHO|HII, A_NONE, 16'h0, 16'h0, 1'b1);

    // andi R5,R2,imm
    fetch(32'h6A900000);
    cyc("andi_T3", RUN|YI,    A_NONE, 16'h0, 16'h0004, 1'b1);
    cyc("andi_T4", RUN|CO|ZI, A_AND,  16'h0, 16'h0, 1'b1);
    cyc("andi_T5", RUN|ZLO,   A_NONE, 16'h0020, 16'h0, 1'b1);

    // neg R4,R6
    fetch(32'h8A300000);
    cyc("neg_T3", RUN|ZI,  A_NEG,  16'h0, 16'h0040, 1'b1);
    cyc("neg_T4", RUN|ZLO, A_NONE, 16'h0010, 16'h0, 1'b1);

    // mflo R7
    fetch(32'hCB800000);
    cyc("mflo_T3", RUN|LOO, A_NONE, 16'h0080, 16'h0, 1'b1);

    // unsupported opcode 11111
    fetch(32'hF8000000);
    cyc("illegal_T3", RUN|ILL, A_NONE, 16'h0, 16'h0, 1'b1);

    // nop goes straight back to T0
    fetch(32'hD0000000);

    // st R1,imm(R2) with memory never ready
    fetch(32'h10900000);
    cyc("st_T3", RUN|YI,       A_NONE, 16'h0, 16'h0004, 1'b0);
    cyc("st_T4", RUN|CO|ZI,    A_ADD,  16'h0, 16'h0, 1'b0);
    cyc("st_T5", RUN|ZLO|MARI, A_NONE, 16'h0, 16'h0, 1'b0);
    cyc("st_T6", RUN|MDRI,     A_NONE, 16'h0, 16'h0002, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc("st_T7_wait", RUN|WR, A_NONE, 16'h0, 16'h0, 1'b0);
    end
    cyc("timeout_halt", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("timeout_halt", NONE, A_NONE, 16'h0, 16'h0, 1'b1);

    // reset while halted, then the halt opcode
    reset = 1'b0;
    cyc("reset_in_halt", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    reset = 1'b1;
    cyc("idle", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    fetch(32'hD8000000);
    cyc("halt", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    cyc("halt", NONE, A_NONE, 16'h0, 16'h0, 1'b1);

    // reset in the middle of a fetch memory wait
    reset = 1'b0;
    cyc("reset_in_halt", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    reset = 1'b1;
    cyc("idle", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    bus.IR_q = 32'hD0000000;
    cyc("T0", RUN|PCO|MARI|INC|ZI, A_NONE, 16'h0, 16'h0, 1'b0);
    cyc("T1_wait", RUN|ZLO|PCI|RD|MDRI, A_NONE, 16'h0, 16'h0, 1'b0);
    cyc("T1_wait", RUN|ZLO|PCI|RD|MDRI, A_NONE, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    cyc("reset_in_wait", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    reset = 1'b1;
    cyc("idle", NONE, A_NONE, 16'h0, 16'h0, 1'b1);
    fetch(32'hD0000000);
    cyc("T0_after_nop", RUN|PCO|MARI|INC|ZI, A_NONE, 16'h0, 16'h0, 1'b1);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
